pc_sequencer: RTL

//  Next-PC controller that sequences the PC register. Each cycle it chooses the PC register's input from:

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_next_mux.sv | 34 +++
 rtl/pc_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: default PC width, FSM states and next-PC select codes.
package pc_pkg;

    localparam int unsigned PC_WIDTH = 14;

    // 2'd3 is unused and recovers to ST_IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_RST
    } sel_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selector: picks hold / +1 / branch / jump / reset vector and flags sequential wrap.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int unsigned        WIDTH     = PC_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0
) (
    input  sel_e                  sel_i,
    input  logic [WIDTH-1:0]      pc_cur_i,
    input  logic [WIDTH-1:0]      br_target_i,
    input  logic [WIDTH-1:0]      jmp_target_i,
    output logic [WIDTH-1:0]      pc_next_o,
    output logic                  wrap_o
);

    localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        pc_next_o = pc_cur_i;
        wrap_o    = 1'b0;
        case (sel_i)
            SEL_HOLD: pc_next_o = pc_cur_i;
            SEL_SEQ: begin
                pc_next_o = pc_cur_i + PC_ONE;
                wrap_o    = &pc_cur_i;
            end
            SEL_BR:   pc_next_o = br_target_i;
            SEL_JMP:  pc_next_o = jmp_target_i;
            SEL_RST:  pc_next_o = RESET_VEC;
            default:  pc_next_o = pc_cur_i;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller with IDLE/RUN/HALT FSM, redirect priority decode and pipeline flushes.
// Optional perf counters (redirects, stalls) are built when PC_SEQ_PERF_EN is defined.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned        WIDTH     = PC_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0
`ifdef PC_SEQ_PERF_EN
    , parameter int unsigned      CNT_WIDTH = 16
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [WIDTH-1:0]      i_pc_cur,
    input  logic                  i_start,
    input  logic                  i_stall,
    input  logic                  i_br_taken,
    input  logic [WIDTH-1:0]      i_br_target,
    input  logic                  i_jmp,
    input  logic [WIDTH-1:0]      i_jmp_target,
    input  logic                  i_halt,
    output logic [WIDTH-1:0]      o_pc_next,
    output logic                  o_fetch_valid,
    output logic                  o_flush_ifid,
    output logic                  o_flush_idex,
    output logic                  o_halted,
`ifdef PC_SEQ_PERF_EN
    output logic [CNT_WIDTH-1:0]  o_redirect_cnt,
    output logic [CNT_WIDTH-1:0]  o_stall_cnt,
`endif
    output logic                  o_wrap
);

    state_e state_q, state_d;
    sel_e   sel;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start) state_d = ST_RUN;
            ST_RUN:  if (!i_br_taken && !i_stall && !i_jmp && i_halt) state_d = ST_HALT;
            ST_HALT: if (i_start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel          = SEL_HOLD;
        o_flush_ifid = 1'b0;
        o_flush_idex = 1'b0;
        case (state_q)
            ST_IDLE: sel = SEL_RST;
            ST_RUN: begin
                if (i_br_taken) begin
                    sel          = SEL_BR;
                    o_flush_ifid = 1'b1;
                    o_flush_idex = 1'b1;
                end else if (i_stall) begin
                    sel = SEL_HOLD;
                end else if (i_jmp) begin
                    sel          = SEL_JMP;
                    o_flush_ifid = 1'b1;
                end else if (i_halt) begin
                    sel          = SEL_HOLD;
                    o_flush_ifid = 1'b1;
                end else begin
                    sel = SEL_SEQ;
                end
            end
            ST_HALT: begin
                if (i_br_taken) begin
                    sel          = SEL_BR;
                    o_flush_ifid = 1'b1;
                    o_flush_idex = 1'b1;
                end
            end
            default: sel = SEL_RST;
        endcase
    end

    assign o_fetch_valid = (state_q == ST_RUN);
    assign o_halted      = (state_q == ST_HALT);

    pc_next_mux #(
        .WIDTH     (WIDTH),
        .RESET_VEC (RESET_VEC)
    ) u_mux (
        .sel_i        (sel),
        .pc_cur_i     (i_pc_cur),
        .br_target_i  (i_br_target),
        .jmp_target_i (i_jmp_target),
        .pc_next_o    (o_pc_next),
        .wrap_o       (o_wrap)
    );

`ifdef PC_SEQ_PERF_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 redir_inc, stall_inc;
    logic [CNT_WIDTH-1:0] redir_cnt_q, redir_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        redir_inc = ((state_q == ST_RUN) || (state_q == ST_HALT)) && i_br_taken;
        redir_inc = redir_inc || ((state_q == ST_RUN) && !i_br_taken && !i_stall && i_jmp);
        stall_inc = (state_q == ST_RUN) && i_stall && !i_br_taken;
        redir_cnt_d = redir_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (redir_inc && (redir_cnt_q != '1)) redir_cnt_d = redir_cnt_q + CNT_ONE;
        if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            redir_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            redir_cnt_q <= redir_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_redirect_cnt = redir_cnt_q;
    assign o_stall_cnt    = stall_cnt_q;
`endif

endmodule
